spi_slave_ctrl: RTL
===================

Name: spi_slave_ctrl

Overview:
- SPI slave front-end and sequencer for the 256x8 command-driven RAM.
- Deserializes MOSI frames into 10-bit command words (bits [9:8] = command, [7:0] = payload) and issues them to the RAM with an rx_valid pulse.
- On a read-data command, waits for the RAM's tx_valid, then serializes the returned byte on MISO.
- SPI is sampled in the clk domain: one MOSI bit per clk rising edge while ss_n is low.

Parameters:
- DATA_W, 8, RAM data/address payload width.
- CMD_W, 10, command word width (DATA_W+2).
- TO_CYCLES, 16, read-wait timeout in clk cycles; used only with SPI_RD_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all sampling on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ss_n  input  1  SPI slave select, active-low.
- mosi  input  1  serial data in, MSB first.
- miso  output  1  serial data out, MSB first.
- rx_data  output  CMD_W  command word to RAM.
- rx_valid  output  1  one-cycle strobe qualifying rx_data.
- tx_data  input  DATA_W  read byte from RAM.
- tx_valid  input  1  RAM read data valid, level.
- rd_err  output  1  read timeout flag; present only with SPI_RD_TIMEOUT_EN.

Behaviour:
- Reset values: miso=0, rx_data=0, rx_valid=0, rd_err=0, state=IDLE, addr_rcvd=0, bit counter=0.
- Frame format: 1 select bit (0=write path, 1=read path), then CMD_W command bits, MSB first.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
  - IDLE: stay while ss_n=1; ss_n=0 -> CHK_CMD.
  - CHK_CMD: samples the select bit.
    - mosi=0 -> WRITE.
    - mosi=1 and addr_rcvd=0 -> READ_ADD.
    - mosi=1 and addr_rcvd=1 -> READ_DATA.
  - WRITE / READ_ADD: shift in CMD_W bits over exactly CMD_W cycles.
    - rx_valid=1 for one cycle, with rx_data stable, on the cycle after the last bit is sampled; then return to IDLE.
    - READ_ADD additionally sets addr_rcvd=1 when rx_valid fires.
  - READ_DATA: shift in CMD_W bits and emit them with rx_valid as in WRITE, then wait for tx_valid.
    - On the first cycle tx_valid=1, latch tx_data.
    - Drive latched bits [7:0] on miso, MSB first, one per cycle for 8 cycles.
    - Then miso=0, clear addr_rcvd, hold until ss_n=1.
- ss_n=1 in any non-IDLE state -> IDLE on the next edge.
  - Partial frame discarded; no rx_valid.
  - Abort wins if it coincides with the last bit.
  - addr_rcvd is unchanged by an abort.
- miso is 0 whenever not actively shifting read data.
- rx_data holds its last value between strobes.
- The command bits are not checked against the path; the RAM decodes bits [9:8].
- Async reset mid-frame returns all state to reset values immediately.

Optional Feature:
- Macro: SPI_RD_TIMEOUT_EN.
- Defined:
  - While waiting for tx_valid in READ_DATA, a counter runs.
  - If TO_CYCLES elapse with no tx_valid, rd_err=1 (sticky until the next ss_n falling edge), miso sends 8 zeros, and addr_rcvd is cleared.
- Undefined: no rd_err port; the wait is unbounded.

Decomposition:
- Package spi_pkg holds:
  - state enum;
  - command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - width constants.
- One sub-module: spi_piso_tx (8-bit load/shift serializer with done flag), used for the miso path.

Test Plan:
- Write frame: ss_n=0; mosi select 0, then 00_0000_0101 -> one rx_valid pulse with rx_data=10'h005; next frame 01_1010_1010 -> rx_data=10'h1AA.
- Read-address frame: select 1, addr_rcvd=0, then 10_0000_0101 -> rx_data=10'h205, addr_rcvd=1.
- Read-data frame:
  - Stimulus: select 1, bits 11_xxxx_xxxx; tx_valid raised 2 cycles after rx_valid with tx_data=8'hAA.
  - Response: miso=1,0,1,0,1,0,1,0 on consecutive cycles; addr_rcvd then 0.
- Abort: ss_n=1 after 6 bits of a write frame -> no rx_valid, state IDLE; ss_n=1 on the 10th bit also gives no rx_valid.
- Async reset asserted mid read-data shift -> miso=0, rx_valid=0, addr_rcvd=0 immediately.
- SPI_RD_TIMEOUT_EN with TO_CYCLES=16 and tx_valid held 0 -> rd_err=1 at cycle 16, miso all zeros, addr_rcvd cleared.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI slave front-end
//
// Contents: state_t (main sequencer states), rd_phase_t (sub-phases of the
// READ_DATA state), RAM command codes, and width/timeout constants.
package spi_pkg;

    localparam int DATA_W    = 8;
    localparam int CMD_W     = DATA_W + 2;
    localparam int BIT_W     = $clog2(CMD_W);
    localparam int TO_CYCLES = 16;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    // READ_DATA walks through these: receive the command word, wait for the
    // RAM, serialize the byte, then idle on miso=0 until ss_n rises.
    typedef enum logic [1:0] {
        RD_CMD   = 2'd0,
        RD_WAIT  = 2'd1,
        RD_SHIFT = 2'd2,
        RD_HOLD  = 2'd3
    } rd_phase_t;

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// rtl/spi_slave_ctrl_if.sv - SPI pins plus RAM command/readback handshake
//
// Signals: ss_n, mosi, miso (SPI side); rx_data, rx_valid (command word to
// RAM); tx_data, tx_valid (read byte from RAM); rd_err (read timeout flag,
// present only when SPI_RD_TIMEOUT_EN is defined).
// Modports: slave (the controller), master (SPI host + RAM model).
interface spi_slave_ctrl_if;
    import spi_pkg::*;

    logic              ss_n;
    logic              mosi;
    logic              miso;
    logic [CMD_W-1:0]  rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
`ifdef SPI_RD_TIMEOUT_EN
    logic              rd_err;

    modport slave  (input  ss_n, mosi, tx_data, tx_valid,
                    output miso, rx_data, rx_valid, rd_err);
    modport master (output ss_n, mosi, tx_data, tx_valid,
                    input  miso, rx_data, rx_valid, rd_err);
`else
    modport slave  (input  ss_n, mosi, tx_data, tx_valid,
                    output miso, rx_data, rx_valid);
    modport master (output ss_n, mosi, tx_data, tx_valid,
                    input  miso, rx_data, rx_valid);
`endif

endinterface

// File: rtl/spi_piso_tx.sv
// rtl/spi_piso_tx.sv - byte load/shift serializer driving miso
//
// Ports: clk, rst_n (async active-low); clr (drop any byte in flight);
// load/data (capture a byte); sout (current bit, MSB first, 0 when idle);
// done (high while the last bit of the byte is on sout).
module spi_piso_tx
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              sout,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sh;
    logic [CNT_W-1:0]  cnt;

    // cnt holds the number of bits still to present, including the one on sout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh  <= '0;
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            sh  <= data;
            cnt <= CNT_W'(DATA_W);
        end else if (cnt != '0) begin
            sh  <= {sh[DATA_W-2:0], 1'b0};
            cnt <= cnt - 1'b1;
        end
    end

    assign sout = (cnt != '0) & sh[DATA_W-1];
    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI slave deserializer and RAM command sequencer
//
// Ports: clk, rst_n (async active-low); bus (spi_slave_ctrl_if.slave):
// ss_n/mosi in, miso out, rx_data/rx_valid command strobe to RAM,
// tx_data/tx_valid read byte from RAM, rd_err read timeout flag.
// Optional: SPI_RD_TIMEOUT_EN bounds the tx_valid wait to TO_CYCLES and
// adds the sticky rd_err output; when undefined the wait is unbounded.
module spi_slave_ctrl
    import spi_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    spi_slave_ctrl_if.slave bus
);

    state_t            state;
    state_t            state_next;
    rd_phase_t         rd_phase;
    logic [BIT_W-1:0]  bit_cnt;
    logic [CMD_W-2:0]  shreg;
    logic              addr_rcvd;
    logic              last_bit;
    logic              cmd_phase;
    logic              piso_load;
    logic              piso_done;
    logic              piso_sout;
    logic [DATA_W-1:0] piso_data;
    logic              to_hit;

`ifdef SPI_RD_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES);
    logic [TO_W-1:0] wait_cnt;
    logic            ss_n_q;

    assign to_hit = (state == READ_DATA) && (rd_phase == RD_WAIT) && !bus.ss_n &&
                    !bus.tx_valid && (wait_cnt == TO_W'(TO_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    assign last_bit  = (bit_cnt == BIT_W'(CMD_W - 1));
    // Command bits are shifted in WRITE/READ_ADD and in the first phase of READ_DATA.
    assign cmd_phase = (state != READ_DATA) || (rd_phase == RD_CMD);

    // On a timeout the serializer is fed zeros so the host still clocks 8 bits.
    assign piso_load = (state == READ_DATA) && (rd_phase == RD_WAIT) && !bus.ss_n &&
                       (bus.tx_valid || to_hit);
    assign piso_data = bus.tx_valid ? bus.tx_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!bus.ss_n) state_next = CHK_CMD;
            end
            CHK_CMD: begin
                if (bus.ss_n)       state_next = IDLE;
                else if (!bus.mosi) state_next = WRITE;
                else if (addr_rcvd) state_next = READ_DATA;
                else                state_next = READ_ADD;
            end
            WRITE, READ_ADD: begin
                if (bus.ss_n || last_bit) state_next = IDLE;
            end
            READ_DATA: begin
                if (bus.ss_n) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            bit_cnt      <= '0;
            shreg        <= '0;
            addr_rcvd    <= 1'b0;
            rd_phase     <= RD_CMD;
`ifdef SPI_RD_TIMEOUT_EN
            wait_cnt     <= '0;
            ss_n_q       <= 1'b1;
            bus.rd_err   <= 1'b0;
`endif
        end else begin
            bus.rx_valid <= 1'b0;
`ifdef SPI_RD_TIMEOUT_EN
            ss_n_q <= bus.ss_n;
            if (ss_n_q && !bus.ss_n) bus.rd_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                end
                CHK_CMD: begin
                    bit_cnt  <= '0;
                    rd_phase <= RD_CMD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    // ss_n high aborts: nothing is committed, even on the last bit.
                    if (!bus.ss_n) begin
                        if (cmd_phase) begin
                            shreg   <= {shreg[CMD_W-3:0], bus.mosi};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (last_bit) begin
                                bus.rx_data  <= {shreg, bus.mosi};
                                bus.rx_valid <= 1'b1;
                                bit_cnt      <= '0;
                                if (state == READ_ADD) addr_rcvd <= 1'b1;
                                if (state == READ_DATA) begin
                                    rd_phase <= RD_WAIT;
`ifdef SPI_RD_TIMEOUT_EN
                                    wait_cnt <= '0;
`endif
                                end
                            end
                        end else begin
                            case (rd_phase)
                                RD_WAIT: begin
                                    if (bus.tx_valid) begin
                                        rd_phase <= RD_SHIFT;
                                    end else if (to_hit) begin
                                        rd_phase  <= RD_SHIFT;
                                        addr_rcvd <= 1'b0;
`ifdef SPI_RD_TIMEOUT_EN
                                        bus.rd_err <= 1'b1;
                                    end else begin
                                        wait_cnt <= wait_cnt + 1'b1;
`endif
                                    end
                                end
                                RD_SHIFT: begin
                                    if (piso_done) begin
                                        rd_phase  <= RD_HOLD;
                                        addr_rcvd <= 1'b0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    spi_piso_tx u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.ss_n),
        .load  (piso_load),
        .data  (piso_data),
        .sout  (piso_sout),
        .done  (piso_done)
    );

    assign bus.miso = piso_sout;

endmodule
